// File: rtl/axi_pkg.sv
// Shared AXI4 types, burst/response encodings and the write-path FSM state enum.
package axi_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 4;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;
  typedef logic [ID_WIDTH-1:0]   id_t;
  typedef logic [7:0]            len_t;
  typedef logic [2:0]            size_t;
  typedef logic [1:0]            burst_t;
  typedef logic [1:0]            resp_t;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;
  localparam burst_t BURST_RSVD  = 2'b11;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;
endpackage

// File: rtl/axi4_beat_addr_calc.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; shared by read and write paths.
module axi4_beat_addr_calc #(
  parameter int ADDR_WIDTH = axi_pkg::ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  import axi_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] bytes, span, lower, incr;

  always_comb begin
    bytes     = ONE << size;
    span      = bytes * (ADDR_WIDTH'(len) + ONE);
    lower     = addr & ~(span - ONE);
    incr      = addr + bytes;
    next_addr = addr;
    case (burst)
      // aligning each step makes an unaligned first beat snap onto the size grid
      BURST_INCR: next_addr = (addr & ~(bytes - ONE)) + bytes;
      BURST_WRAP: next_addr = (incr == lower + span) ? lower : incr;
      default:    next_addr = addr;
    endcase
  end
endmodule

// File: rtl/axi4_wr_slave_ctrl.sv
// AXI4 write-path slave: one burst at a time, registered memory write port, one B per burst.
// Optional AXI4_WR_LAST_CHECK_EN: flag wlast/beat-count disagreement as SLVERR.
module axi4_wr_slave_ctrl #(
  parameter int ADDR_WIDTH = axi_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi_pkg::DATA_WIDTH,
  parameter int ID_WIDTH   = axi_pkg::ID_WIDTH,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_strb
);
  import axi_pkg::*;

  localparam logic [1:0] S_IDLE   = WR_IDLE;
  localparam logic [1:0] S_DATA   = WR_DATA;
  localparam logic [1:0] S_RESP   = WR_RESP;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));

  logic [1:0]            state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q, next_addr;
  logic [7:0]            len_q, cnt;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  aw_err, last_err, aw_illegal, last_beat;

  assign awready   = (state == S_IDLE);
  assign wready    = (state == S_DATA);
  assign bvalid    = (state == S_RESP);
  assign bid       = id_q;
  assign bresp     = (aw_err | last_err) ? RESP_SLVERR : RESP_OKAY;
  assign last_beat = (cnt == len_q);

  always_comb begin
    aw_illegal = (awburst == BURST_RSVD) || (awsize > MAX_SIZE) ||
                 ((awburst == BURST_WRAP) &&
                  !(awlen == 8'd1 || awlen == 8'd3 || awlen == 8'd7 || awlen == 8'd15));
  end

  axi4_beat_addr_calc #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_calc (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

`ifndef AXI4_WR_LAST_CHECK_EN
  logic unused_wlast;
  assign unused_wlast = wlast;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= S_IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt       <= '0;
      aw_err    <= 1'b0;
      last_err  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_strb  <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: if (awvalid) begin
          id_q     <= awid;
          addr_q   <= awaddr;
          len_q    <= awlen;
          size_q   <= awsize;
          burst_q  <= awburst;
          cnt      <= '0;
          aw_err   <= aw_illegal;
          last_err <= 1'b0;
          state    <= S_DATA;
        end
        S_DATA: if (wvalid) begin
          // a bad burst never touches the memory port, not even its payload
          if (!aw_err) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr_q;
            mem_wdata <= wdata;
            mem_strb  <= wstrb;
          end
          addr_q <= next_addr;
          cnt    <= cnt + 8'd1;
`ifdef AXI4_WR_LAST_CHECK_EN
          if (wlast != last_beat) last_err <= 1'b1;
`endif
          if (last_beat) state <= S_RESP;
        end
        S_RESP: if (bready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_wr_slave_ctrl.sv
// Randomized self-checking bench for axi4_wr_slave_ctrl with a spec-level address/legality model.
module tb_axi4_wr_slave_ctrl;
  localparam int TMO = 200;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          c;
  } wr_t;
  wr_t memq[$];

  axi4_wr_slave_ctrl dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strb(mem_strb)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;
  always @(negedge aclk) if (mem_we) memq.push_back('{mem_addr, mem_wdata, mem_strb, cyc});

  function automatic bit model_illegal(logic [7:0] len, logic [2:0] size, logic [1:0] b);
    return (b == 2'b11) || ((32'd1 << size) > 32'd4) ||
           (b == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // closed-form beat address; WRAP assumes the start address is size-aligned
  function automatic logic [31:0] exp_addr(logic [31:0] a, logic [7:0] len, logic [2:0] size,
                                           logic [1:0] b, int n);
    logic [31:0] bytes, span, lower;
    bytes = 32'd1 << size;
    if (b == 2'b00) return a;
    if (b == 2'b01) return (n == 0) ? a : (a / bytes) * bytes + 32'(n) * bytes;
    span  = bytes * (32'(len) + 32'd1);
    lower = (a / span) * span;
    return lower + ((a - lower + 32'(n) * bytes) % span);
  endfunction

  task automatic run_burst(input string nm, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] b,
                           input int early_last, input int bp, input bit gaps);
    logic [31:0] dq[$];
    logic [3:0]  sq[$];
    int          hsq[$];
    int          t, nexp;
    bit          ok, lerr;
    logic [1:0]  eresp;
    logic [31:0] ea;

    memq.delete();
    lerr = 1'b0;
    @(posedge aclk); #1;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = b;
    t = 0;
    do begin @(negedge aclk); ok = awready; @(posedge aclk); #1; t++; end while (!ok && t < TMO);
    awvalid = 1'b0;
    if (!ok) begin
      failures++; $display("FAIL %s aw_timeout awready=%b required=1", nm, awready);
      return;
    end

    for (int n = 0; n <= int'(len); n++) begin
      if (gaps) begin
        t = $urandom_range(0, 2);
        wvalid = 1'b0;
        repeat (t) begin @(posedge aclk); #1; end
      end
      wvalid = 1'b1;
      wdata  = $urandom;
      wstrb  = 4'($urandom);
      wlast  = (n == int'(len)) || (n == early_last);
      if (n == early_last || (early_last >= 0 && n == int'(len))) lerr = 1'b1;
      dq.push_back(wdata); sq.push_back(wstrb);
      t = 0;
      do begin
        @(negedge aclk); ok = wready;
        if (n == 0 && t == 0 && !gaps) begin
          checks++;
          if (wready !== 1'b1) begin
            failures++; $display("FAIL %s aw_to_w_latency wready=%b required=1", nm, wready);
          end
        end
        @(posedge aclk); #1; t++;
      end while (!ok && t < TMO);
      if (!ok) begin
        wvalid = 1'b0;
        failures++; $display("FAIL %s w_timeout beat=%0d", nm, n);
        return;
      end
      hsq.push_back(cyc);
    end
    wvalid = 1'b0; wlast = 1'b0;

`ifdef AXI4_WR_LAST_CHECK_EN
    eresp = (model_illegal(len, size, b) || (early_last >= 0 && early_last < int'(len))) ? 2'b10 : 2'b00;
`else
    eresp = model_illegal(len, size, b) ? 2'b10 : 2'b00;
`endif

    @(negedge aclk);
    checks++;
    if ({bvalid, bid, bresp} !== {1'b1, id, eresp}) begin
      failures++;
      $display("FAIL %s b_resp bvalid=%b bid=%h bresp=%b required 1 %h %b", nm, bvalid, bid, bresp, id, eresp);
    end
    for (int i = 0; i < bp; i++) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      checks++;
      if ({bvalid, bid, bresp, awready, wready} !== {1'b1, id, eresp, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL %s b_hold cyc=%0d bvalid=%b bid=%h bresp=%b awready=%b required 1 %h %b 0",
                 nm, i, bvalid, bid, bresp, awready, id, eresp);
      end
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    @(negedge aclk);
    checks++;
    if ({awready, bvalid} !== 2'b10) begin
      failures++; $display("FAIL %s b_done awready=%b bvalid=%b required 1 0", nm, awready, bvalid);
    end

    nexp = model_illegal(len, size, b) ? 0 : int'(len) + 1;
    checks++;
    if (memq.size() != nexp) begin
      failures++; $display("FAIL %s write_count got=%0d required=%0d", nm, memq.size(), nexp);
    end else begin
      for (int n = 0; n < nexp; n++) begin
        ea = exp_addr(addr, len, size, b, n);
        checks++;
        if (memq[n].a !== ea || memq[n].d !== dq[n] || memq[n].s !== sq[n] || memq[n].c != hsq[n]) begin
          failures++;
          $display("FAIL %s beat%0d addr=%h data=%h strb=%h cyc=%0d required %h %h %h %0d",
                   nm, n, memq[n].a, memq[n].d, memq[n].s, memq[n].c, ea, dq[n], sq[n], hsq[n]);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge aclk);
    #1;
    @(negedge aclk);
    checks++;
    if ({awready, wready, bvalid, bid, bresp, mem_we, mem_addr, mem_wdata, mem_strb} !==
        {1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 32'h0, 32'h0, 4'h0}) begin
      failures++;
      $display("FAIL reset_values awready=%b wready=%b bvalid=%b bid=%h bresp=%b mem_we=%b addr=%h data=%h strb=%h required 1 0 0 0 00 0 0 0 0",
               awready, wready, bvalid, bid, bresp, mem_we, mem_addr, mem_wdata, mem_strb);
    end
    @(posedge aclk); #1;
    areset = 1'b0;
  endtask

  task automatic test_incr();
    run_burst("incr4", 4'h9, 32'h100, 8'd3, 3'd2, 2'b01, -1, 0, 1'b0);
    run_burst("incr_top_wrap", 4'h2, 32'hFFFF_FFF8, 8'd3, 3'd2, 2'b01, -1, 0, 1'b0);
  endtask

  task automatic test_wrap();
    run_burst("wrap4", 4'h3, 32'h108, 8'd3, 3'd2, 2'b10, -1, 0, 1'b0);
    run_burst("wrap2_byte", 4'h4, 32'h7, 8'd1, 3'd0, 2'b10, -1, 1, 1'b0);
  endtask

  task automatic test_fixed_unaligned();
    run_burst("fixed3", 4'h1, 32'h40, 8'd2, 3'd2, 2'b00, -1, 0, 1'b0);
    run_burst("incr_unaligned", 4'h6, 32'h103, 8'd1, 3'd2, 2'b01, -1, 0, 1'b0);
  endtask

  task automatic test_illegal();
    run_burst("ill_rsvd", 4'hA, 32'h200, 8'd2, 3'd2, 2'b11, -1, 0, 1'b0);
    run_burst("ill_wrap_len2", 4'hB, 32'h200, 8'd2, 3'd2, 2'b10, -1, 0, 1'b0);
    run_burst("ill_size3", 4'hC, 32'h200, 8'd1, 3'd3, 2'b01, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_burst("b_backpressure", 4'hD, 32'h300, 8'd1, 3'd2, 2'b01, -1, 5, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    memq.delete();
    @(posedge aclk); #1;
    awvalid = 1'b1; awid = 4'h7; awaddr = 32'h500; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h1111_0000; wstrb = 4'hF; wlast = 1'b0;
    @(posedge aclk); #1;
    wdata = 32'h1111_0001;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if ({awready, wready, bvalid, bid, bresp, mem_we, mem_addr, mem_wdata, mem_strb} !==
        {1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 32'h0, 32'h0, 4'h0}) begin
      failures++;
      $display("FAIL mid_reset_values awready=%b wready=%b bvalid=%b bid=%h bresp=%b mem_we=%b addr=%h required 1 0 0 0 00 0 0",
               awready, wready, bvalid, bid, bresp, mem_we, mem_addr);
    end
    checks++;
    if (memq.size() != 2) begin
      failures++; $display("FAIL mid_reset_writes got=%0d required=2", memq.size());
    end
    run_burst("after_reset_1beat", 4'h5, 32'h600, 8'd0, 3'd2, 2'b01, -1, 0, 1'b0);
  endtask

  task automatic test_last_check();
    run_burst("early_wlast", 4'hE, 32'h700, 8'd3, 3'd2, 2'b01, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0]  b;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [31:0] addr;
    for (int k = 0; k < 25; k++) begin
      b    = 2'($urandom_range(0, 3));
      size = 3'($urandom_range(0, 3));
      len  = 8'($urandom_range(0, 15));
      if (b == 2'b10 && $urandom_range(0, 3) != 0) len = 8'((2 << $urandom_range(0, 3)) - 1);
      addr = $urandom;
      if (b == 2'b10) addr = (addr >> size) << size;
      run_burst($sformatf("rand%0d", k), 4'($urandom), addr, len, size, b, -1,
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_fixed_unaligned();
    test_illegal();
    test_backpressure();
    test_reset_mid_burst();
    test_last_check();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
